// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Multiplies by 32-step shift-add and divides by 32-step restoring division, then applies a sign fix.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        done_q, done_d;

  logic        is_md, is_mv, accept;
  logic        op_signed, op_div, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next, prod_fix;

  // Instruction decode and operand magnitudes
  always_comb begin
    is_md     = start && (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU);
    is_mv     = start && (funct == F_MFHI || funct == F_MFLO || funct == F_MTHI || funct == F_MTLO);
    accept    = is_md && (state_q == S_IDLE);
    op_signed = (funct == F_MULT) || (funct == F_DIV);
    op_div    = funct[1];
    sign_a    = op_signed && srca[31];
    sign_b    = op_signed && srcb[31];
    mag_a     = sign_a ? (~srca + 32'd1) : srca;
    mag_b     = sign_b ? (~srcb + 32'd1) : srcb;
  end

  // One iteration of each algorithm; the low half of acc holds the multiplier or dividend bits
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    prod_fix  = qneg_q ? (~acc_q + 64'd1) : acc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d    = {32'd0, op_div ? mag_a : mag_b};
          opnd_d   = op_div ? mag_b : mag_a;
          is_div_d = op_div;
          qneg_d   = sign_a ^ sign_b;
          rneg_d   = sign_a;
          cnt_d    = '0;
        end else if (start && funct == F_MTHI) begin
          hi_d = srca;
        end else if (start && funct == F_MTLO) begin
          lo_d = srca;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = is_div_q ? div_next : mul_next;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (is_div_q) begin
          // Zero divisor leaves quotient all ones and remainder = dividend magnitude;
          // restoring the dividend sign gives back the original srca.
          lo_d = (qneg_q && opnd_q != 32'd0) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
          hi_d = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    stall  = busy && (is_md || is_mv);
    done   = done_q;
    result = '0;
    if (funct == F_MFHI)      result = hi_q;
    else if (funct == F_MFLO) result = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random ops against an arithmetic model.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] srca, srcb;
  logic        busy, stall, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .srca(srca), .srcb(srcb), .busy(busy), .stall(stall),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS semantics for HI/LO
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint      sp, q, r;
    logic [63:0] up;
    hi = '0;
    lo = '0;
    case (f)
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32];
        lo = sp[31:0];
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      F_DIV, F_DIVU: begin
        if (b == 32'd0) begin
          lo = 32'hFFFFFFFF;
          hi = a;
        end else if (f == F_DIV) begin
          q  = longint'($signed(a)) / longint'($signed(b));
          r  = longint'($signed(a)) % longint'($signed(b));
          lo = q[31:0];
          hi = r[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eh, el;
    int busy_cyc, done_cnt;
    model(f, a, b, eh, el);
    start = 1'b1; funct = f; srca = a; srcb = b;
    tick();
    start = 1'b0; funct = 6'd0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      busy_cyc++;
      if (done) done_cnt++;
      tick();
    end
    chk({tag, " busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, " busy_cycles"}, busy_cyc, 32'd33);
    chk({tag, " done_early"}, done_cnt, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    funct = F_MFHI; #1;
    chk({tag, " hi"}, result, eh);
    funct = F_MFLO; #1;
    chk({tag, " lo"}, result, el);
    funct = 6'd0;
    tick();
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    $display("op f=%b a=%h b=%h exp hi=%h lo=%h busy=%0d", f, a, b, eh, el, busy_cyc);
  endtask

  initial begin
    int stall_cyc, busy_wait;
    logic [5:0] ops [4];
    logic [5:0] rf;
    logic [31:0] ra, rb;
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

    reset = 1'b0; start = 1'b0; funct = 6'd0; srca = '0; srcb = '0;
    tick(); tick();
    start = 1'b1; funct = F_MFHI; #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset hi", result, 32'd0);
    funct = F_MFLO; #1;
    chk("reset lo", result, 32'd0);
    start = 1'b0; funct = 6'd0;
    tick();
    reset = 1'b1;
    tick();

    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
    run_op(F_MULT,  32'hFFFFFFFD, 32'h00000005, "mult neg");
    run_op(F_DIV,   32'hFFFFFFF9, 32'h00000002, "div neg");
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, "div ovf");
    run_op(F_DIVU,  32'h00001234, 32'h00000000, "divu zero");

    // mthi / mtlo in idle
    start = 1'b1; funct = F_MTHI; srca = 32'hCAFEF00D;
    tick();
    chk("mthi busy", {31'd0, busy}, 32'd0);
    funct = F_MTLO; srca = 32'h12345678;
    tick();
    chk("mtlo busy", {31'd0, busy}, 32'd0);
    funct = F_MFHI; #1;
    chk("mfhi after mthi", result, 32'hCAFEF00D);
    funct = F_MFLO; #1;
    chk("mflo after mtlo", result, 32'h12345678);
    start = 1'b0; funct = 6'd0;
    tick();
    $display("mthi/mtlo done");

    // dependent mflo held behind a mult
    start = 1'b1; funct = F_MULT; srca = 32'd2; srcb = 32'd3;
    tick();
    funct = F_MFLO;
    stall_cyc = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      if (stall) stall_cyc++;
      tick();
    end
    chk("hazard stall_cycles", stall_cyc, 32'd33);
    chk("hazard stall_drop", {31'd0, stall}, 32'd0);
    chk("hazard mflo", result, 32'd6);
    start = 1'b0; funct = 6'd0;
    tick();
    $display("hazard mflo stall=%0d", stall_cyc);

    // second muldiv op presented while busy must not be accepted
    start = 1'b1; funct = F_MULT; srca = 32'd7; srcb = 32'd9;
    tick();
    funct = F_MULTU; srca = 32'hFFFFFFFF; srcb = 32'hFFFFFFFF;
    stall_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall) stall_cyc++;
      tick();
    end
    start = 1'b0; funct = 6'd0;
    chk("hazard2 stall", stall_cyc, 32'd10);
    busy_wait = 0;
    while (busy && busy_wait < 60) begin
      busy_wait++;
      tick();
    end
    chk("hazard2 busy_fall", {31'd0, busy}, 32'd0);
    tick();
    funct = F_MFHI; #1;
    chk("hazard2 hi", result, 32'd0);
    funct = F_MFLO; #1;
    chk("hazard2 lo", result, 32'd63);
    funct = 6'd0;
    tick();
    $display("hazard second op rejected stall=%0d", stall_cyc);

    // reset in the middle of a divide
    start = 1'b1; funct = F_MTHI; srca = 32'hDEADBEEF;
    tick();
    funct = F_MTLO; srca = 32'h0BADF00D;
    tick();
    funct = F_DIV; srca = 32'd100; srcb = 32'd7;
    tick();
    start = 1'b0; funct = 6'd0;
    repeat (9) tick();
    chk("midreset busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0; #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    funct = F_MFHI; #1;
    chk("midreset hi", result, 32'd0);
    funct = F_MFLO; #1;
    chk("midreset lo", result, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    funct = F_MFHI; #1;
    chk("postreset hi", result, 32'd0);
    funct = 6'd0;
    $display("mid-op reset cleared state");
    run_op(F_DIV, 32'd100, 32'd7, "post-reset div");

    // random operations
    for (int i = 0; i < 24; i++) begin
      rf = ops[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 16);
        2: ra = 32'h80000000;
        default: ;
      endcase
      run_op(rf, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
